mem_stage_memwb: RTL and testbench

- MEM pipeline stage of the 5-stage MIPS core.
- Consumes the EX/MEM register fields and the forwardM select produced by the lw->sw memory-forwarding unit.
- Performs the data-memory read or write, then registers the results into the MEM/WB pipeline register.
- MEM/WB outputs feed write-back and loop back to the forwarding unit as MEMWB_MemToReg and MEMWB_WriteReg.

---
 rtl/mem_stage_memwb.sv | 81 ++++++++
 tb/tb_mem_stage_memwb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_memwb.sv
// MIPS MEM stage with MEM/WB register. Optional DMEM_CLEAR_EN zeroes data memory on reset.
// Latency: one cycle from EX/MEM inputs to MEMWB_* outputs.
// Backpressure: stall holds MEM/WB and blocks the memory write.
module mem_stage_memwb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              EXMEM_MemRead,
    input  logic              EXMEM_MemWrite,
    input  logic              EXMEM_MemToReg,
    input  logic              EXMEM_RegWrite,
    input  logic [DATA_W-1:0] EXMEM_ALUResult,
    input  logic [DATA_W-1:0] EXMEM_WriteData,
    input  logic [4:0]        EXMEM_WriteReg,
    input  logic              forwardM,
    output logic              MEMWB_RegWrite,
    output logic              MEMWB_MemToReg,
    output logic [4:0]        MEMWB_WriteReg,
    output logic [DATA_W-1:0] MEMWB_ALUResult,
    output logic [DATA_W-1:0] MEMWB_ReadData,
    output logic              MEMWB_Misalign
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] word_idx;
    logic              mem_access;
    logic              misaligned;
    logic [DATA_W-1:0] store_data;
    logic              do_write;
    logic              do_read;

    // Upper address bits are dropped, so the word index wraps.
    assign word_idx   = EXMEM_ALUResult[ADDR_W+1:2];
    assign mem_access = EXMEM_MemRead | EXMEM_MemWrite;
    assign misaligned = mem_access & (|EXMEM_ALUResult[1:0]);
    assign store_data = forwardM ? MEMWB_ReadData : EXMEM_WriteData;
    assign do_write   = ~stall & EXMEM_MemWrite & ~misaligned;
    assign do_read    = EXMEM_MemRead & ~misaligned;

`ifdef DMEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[word_idx] <= store_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem[word_idx] <= store_data;
        end
    end
`endif

    // The read samples mem before the same-edge write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            MEMWB_RegWrite  <= 1'b0;
            MEMWB_MemToReg  <= 1'b0;
            MEMWB_WriteReg  <= '0;
            MEMWB_ALUResult <= '0;
            MEMWB_ReadData  <= '0;
            MEMWB_Misalign  <= 1'b0;
        end else if (!stall) begin
            MEMWB_RegWrite  <= EXMEM_RegWrite & ~misaligned;
            MEMWB_MemToReg  <= EXMEM_MemToReg;
            MEMWB_WriteReg  <= EXMEM_WriteReg;
            MEMWB_ALUResult <= EXMEM_ALUResult;
            MEMWB_ReadData  <= do_read ? mem[word_idx] : '0;
            MEMWB_Misalign  <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage_memwb.sv
// Directed bench for mem_stage_memwb with an expected-result queue.
module tb_mem_stage_memwb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        forward_m;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic        wb_misalign;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_stage_memwb #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .EXMEM_MemRead  (mem_read),
        .EXMEM_MemWrite (mem_write),
        .EXMEM_MemToReg (mem_to_reg),
        .EXMEM_RegWrite (reg_write),
        .EXMEM_ALUResult(alu_result),
        .EXMEM_WriteData(write_data),
        .EXMEM_WriteReg (write_reg),
        .forwardM       (forward_m),
        .MEMWB_RegWrite (wb_reg_write),
        .MEMWB_MemToReg (wb_mem_to_reg),
        .MEMWB_WriteReg (wb_write_reg),
        .MEMWB_ALUResult(wb_alu_result),
        .MEMWB_ReadData (wb_read_data),
        .MEMWB_Misalign (wb_misalign)
    );

    function automatic exp_t mk(input logic rw, input logic mtr, input logic [4:0] wr,
                                input logic [31:0] alu, input logic [31:0] rd, input logic mis);
        exp_t e;
        e.rw = rw; e.mtr = mtr; e.wr = wr; e.alu = alu; e.rd = rd; e.mis = mis;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Drive one EX/MEM slot, queue its expected MEM/WB image, then compare after the edge.
    task automatic op(input string tag, input logic st, input logic rd, input logic wr_en,
                      input logic mtr, input logic rw, input logic [31:0] alu,
                      input logic [31:0] wdata, input logic [4:0] wreg, input logic fwd,
                      input exp_t e);
        exp_t got;
        stall      = st;
        mem_read   = rd;
        mem_write  = wr_en;
        mem_to_reg = mtr;
        reg_write  = rw;
        alu_result = alu;
        write_data = wdata;
        write_reg  = wreg;
        forward_m  = fwd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            chk({tag, ".RegWrite"},  {31'd0, wb_reg_write},  {31'd0, got.rw});
            chk({tag, ".MemToReg"},  {31'd0, wb_mem_to_reg}, {31'd0, got.mtr});
            chk({tag, ".WriteReg"},  {27'd0, wb_write_reg},  {27'd0, got.wr});
            chk({tag, ".ALUResult"}, wb_alu_result,          got.alu);
            chk({tag, ".ReadData"},  wb_read_data,           got.rd);
            chk({tag, ".Misalign"},  {31'd0, wb_misalign},   {31'd0, got.mis});
        end
    endtask

    exp_t zero_e;
    exp_t held_e;
    logic [31:0] after_rst_rd;

    initial begin
        zero_e = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);

        // Reset with random inputs; the second cycle also has stall high.
        rst_n = 1'b0;
        op("rst0", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, 5'($urandom), 1'($urandom), zero_e);
        op("rst1", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, 5'($urandom), 1'($urandom), zero_e);
        rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
        op("clr_lw40", 0, 1, 0, 1, 1, 32'h40, 32'h0, 5'd3, 0,
           mk(1, 1, 5'd3, 32'h40, 32'h0, 0));
`endif

        // Store then load
        op("sw10", 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0,
           mk(0, 0, 5'd0, 32'h10, 32'h0, 0));
        op("lw10", 0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd8, 0,
           mk(1, 1, 5'd8, 32'h10, 32'hDEADBEEF, 0));

        // lw -> sw forwarding
        op("sw20", 0, 0, 1, 0, 0, 32'h20, 32'h12345678, 5'd0, 0,
           mk(0, 0, 5'd0, 32'h20, 32'h0, 0));
        op("lw20", 0, 1, 0, 1, 1, 32'h20, 32'h0, 5'd9, 0,
           mk(1, 1, 5'd9, 32'h20, 32'h12345678, 0));
        op("sw24fwd", 0, 0, 1, 0, 0, 32'h24, 32'h0, 5'd0, 1,
           mk(0, 0, 5'd0, 32'h24, 32'h0, 0));
        op("lw24", 0, 1, 0, 1, 1, 32'h24, 32'h0, 5'd10, 0,
           mk(1, 1, 5'd10, 32'h24, 32'h12345678, 0));

        // Misaligned load and store
        op("lw13mis", 0, 1, 0, 1, 1, 32'h13, 32'h0, 5'd11, 0,
           mk(0, 1, 5'd11, 32'h13, 32'h0, 1));
        op("sw13mis", 0, 0, 1, 0, 0, 32'h13, 32'h55555555, 5'd0, 0,
           mk(0, 0, 5'd0, 32'h13, 32'h0, 1));
        op("lw10post", 0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd12, 0,
           mk(1, 1, 5'd12, 32'h10, 32'hDEADBEEF, 0));

        // Stall three cycles with a store of zero to 0x10 presented
        held_e = mk(1, 1, 5'd12, 32'h10, 32'hDEADBEEF, 0);
        for (int i = 0; i < 3; i++) begin
            op("stall", 1, 0, 1, 0, 0, 32'h10, 32'h0, 5'd1, 0, held_e);
        end
        op("lw10stall", 0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd12, 0,
           mk(1, 1, 5'd12, 32'h10, 32'hDEADBEEF, 0));

        // Address wrap
        op("sw400", 0, 0, 1, 0, 0, 32'h400, 32'hAAAA0000, 5'd0, 0,
           mk(0, 0, 5'd0, 32'h400, 32'h0, 0));
        op("lw000", 0, 1, 0, 1, 1, 32'h0, 32'h0, 5'd4, 0,
           mk(1, 1, 5'd4, 32'h0, 32'hAAAA0000, 0));

        // Simultaneous read and write returns the old word
        op("sw08", 0, 0, 1, 0, 0, 32'h8, 32'h1, 5'd0, 0,
           mk(0, 0, 5'd0, 32'h8, 32'h0, 0));
        op("rw08", 0, 1, 1, 1, 1, 32'h8, 32'h2, 5'd13, 0,
           mk(1, 1, 5'd13, 32'h8, 32'h1, 0));
        op("lw08", 0, 1, 0, 1, 1, 32'h8, 32'h0, 5'd14, 0,
           mk(1, 1, 5'd14, 32'h8, 32'h2, 0));

        // Non-memory op with low address bits set is not misaligned
        op("alu", 0, 0, 0, 0, 1, 32'h12345677, 32'h0, 5'd31, 0,
           mk(1, 0, 5'd31, 32'h12345677, 32'h0, 0));

        // Reset during a stalled pending store
        rst_n = 1'b0;
        op("rststall", 1, 0, 1, 0, 0, 32'h8, 32'hFFFF, 5'd2, 0, zero_e);
        rst_n = 1'b1;
`ifdef DMEM_CLEAR_EN
        after_rst_rd = 32'h0;
`else
        after_rst_rd = 32'h2;
`endif
        op("lw08rst", 0, 1, 0, 1, 1, 32'h8, 32'h0, 5'd15, 0,
           mk(1, 1, 5'd15, 32'h8, after_rst_rd, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
